// File: rtl/sci_frame_master.sv
// Initiator end of the NN serial frame protocol: sends SOF_1 SOF_2 SOF_3 BASE LEN PAYLOAD
// over a byte UART and assembles the response bytes. Define RESP_TIMEOUT_EN for the response watchdog.
module sci_frame_master #(
    parameter logic [7:0] SOF_1          = 8'h55,
    parameter logic [7:0] SOF_2          = 8'hab,
    parameter logic [7:0] SOF_3          = 8'haa,
    parameter int         PAYLOAD_BYTES  = 2,
    parameter int         RESP_BYTES     = 1,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       send_req,
    input  logic [7:0]                 base_addr,
    input  logic [PAYLOAD_BYTES*8-1:0] payload,
    output logic                       busy,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    input  logic                       rx_error,
    output logic [RESP_BYTES*8-1:0]    resp_data,
    output logic                       resp_valid,
    output logic                       resp_err,
    output logic                       timeout
);

    localparam int              IW       = $clog2(PAYLOAD_BYTES + 5);
    localparam logic [IW-1:0]   LAST_IDX = IW'(PAYLOAD_BYTES + 4);
    localparam logic [7:0]      LEN      = 8'(PAYLOAD_BYTES - 1);
    localparam int              RW       = $clog2(RESP_BYTES + 1);
    localparam logic [RW-1:0]   LAST_R   = RW'(RESP_BYTES - 1);
    localparam int              PW       = PAYLOAD_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        START,
        NEXT,
        RESP,
        DONE
    } state_t;

    state_t          state;
    logic [7:0]      base_q;
    logic [PW-1:0]   pay_shift;
    logic [IW-1:0]   byte_idx;
    logic [RW-1:0]   rcnt;
    logic            rx_ready_q;
    logic            rx_edge;

`ifdef RESP_TIMEOUT_EN
    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   tcnt;
`else
    assign timeout = 1'b0;
`endif

    // Bytes are taken on the rising edge of the receiver's level-valid strobe
    assign rx_edge = rx_ready & ~rx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            pay_shift  <= '0;
            byte_idx   <= '0;
            rcnt       <= '0;
            rx_ready_q <= 1'b0;
            busy       <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            tcnt       <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            rx_ready_q <= rx_ready;
            resp_valid <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (send_req) begin
                        base_q    <= base_addr;
                        pay_shift <= payload;
                        byte_idx  <= '0;
                        resp_err  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Payload leaves MSB byte first, so the shift register walks left
                    if (byte_idx == IW'(0)) begin
                        tx_data <= SOF_1;
                    end else if (byte_idx == IW'(1)) begin
                        tx_data <= SOF_2;
                    end else if (byte_idx == IW'(2)) begin
                        tx_data <= SOF_3;
                    end else if (byte_idx == IW'(3)) begin
                        tx_data <= base_q;
                    end else if (byte_idx == IW'(4)) begin
                        tx_data <= LEN;
                    end else begin
                        tx_data   <= pay_shift[PW-1 -: 8];
                        pay_shift <= pay_shift << 8;
                    end
                    state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        state    <= NEXT;
                    end
                end
                NEXT: begin
                    if (byte_idx == LAST_IDX) begin
                        rcnt      <= '0;
                        resp_data <= '0;
`ifdef RESP_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                        state     <= RESP;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= LOAD;
                    end
                end
                RESP: begin
                    if (rx_edge) begin
                        for (int i = 0; i < RESP_BYTES; i++) begin
                            if (rcnt == RW'(i)) begin
                                resp_data[8*i +: 8] <= rx_data;
                            end
                        end
                        rcnt <= rcnt + 1'b1;
                        if (rx_error) begin
                            resp_err <= 1'b1;
                        end
`ifdef RESP_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (rcnt == LAST_R) begin
                            resp_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= DONE;
                        end
                    end
`ifdef RESP_TIMEOUT_EN
                    else if (tcnt == T_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sci_frame_master.sv
// Directed bench for sci_frame_master with a small UART byte model on each side.
module tb_sci_frame_master;

    localparam int PB = 2;
    localparam int RB = 2;
`ifdef RESP_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1000000;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          send_req = 1'b0;
    logic [7:0]    base_addr = 8'h00;
    logic [15:0]   payload = 16'h0000;
    logic          busy;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b0;
    logic          rx_error = 1'b0;
    logic [15:0]   resp_data;
    logic          resp_valid;
    logic          resp_err;
    logic          timeout;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx_log[$];
    int         tx_cnt = 0;
    bit         tx_hold = 1'b0;
    logic       tx_start_prev = 1'b0;
    int         start_viol = 0;

    int          valid_cnt = 0;
    int          timeout_cnt = 0;
    logic [15:0] valid_data = 16'h0000;
    logic        valid_err = 1'b0;
    logic        valid_busy = 1'b0;

    sci_frame_master #(
        .SOF_1(8'h55), .SOF_2(8'hab), .SOF_3(8'haa),
        .PAYLOAD_BYTES(PB), .RESP_BYTES(RB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .send_req(send_req), .base_addr(base_addr),
        .payload(payload), .busy(busy), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_err(resp_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // UART transmitter model: takes a byte on tx_start, then stays not-ready for 3 cycles
    always @(negedge clk) begin
        if (tx_start && !tx_start_prev && !tx_ready) start_viol++;
        if (tx_start && tx_ready && tx_cnt == 0) begin
            tx_log.push_back(tx_data);
            tx_cnt = 3;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        tx_ready = (tx_cnt == 0) && !tx_hold;
        tx_start_prev = tx_start;
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            valid_cnt++;
            valid_data = resp_data;
            valid_err  = resp_err;
            valid_busy = busy;
        end
        if (timeout) timeout_cnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_send(input logic [7:0] b, input logic [15:0] p);
        @(negedge clk);
        base_addr = b;
        payload   = p;
        send_req  = 1'b1;
        @(negedge clk);
        send_req  = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int c = 0; c < 3000 && tx_log.size() < n; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic e);
        @(negedge clk);
        rx_data  = d;
        rx_error = e;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input int start);
        for (int c = 0; c < 300 && valid_cnt == start; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (resp_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_resp_data: got %h expected 0000", resp_data); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame;
        logic [7:0] exp_b [7] = '{8'h55, 8'hab, 8'haa, 8'h03, 8'h01, 8'ha5, 8'h5a};
        logic [7:0] got;
        int v0;
        tx_log.delete();
        v0 = valid_cnt;
        pulse_send(8'h03, 16'ha55a);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL frame_busy: got %b expected 1", busy); end
        wait_tx(2);
        send_rx(8'hee, 1'b0);
        pulse_send(8'h77, 16'hffff);
        wait_tx(7);
        checks++; if (tx_log.size() != 7) begin failures++; $display("[TB] FAIL frame_len: got %0d expected 7", tx_log.size()); end
        for (int i = 0; i < 7; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin failures++; $display("[TB] FAIL frame_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        repeat (3) @(negedge clk);
        send_rx(8'h34, 1'b0);
        send_rx(8'h12, 1'b0);
        wait_valid(v0);
        checks++; if (valid_cnt - v0 != 1) begin failures++; $display("[TB] FAIL frame_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (valid_data !== 16'h1234) begin failures++; $display("[TB] FAIL frame_resp_data: got %h expected 1234", valid_data); end
        checks++; if (valid_err !== 1'b0) begin failures++; $display("[TB] FAIL frame_resp_err: got %b expected 0", valid_err); end
        checks++; if (valid_busy !== 1'b0) begin failures++; $display("[TB] FAIL frame_busy_at_valid: got %b expected 0", valid_busy); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL frame_valid_pulse: got %b expected 0", resp_valid); end
        repeat (30) @(negedge clk);
        checks++; if (tx_log.size() != 7) begin failures++; $display("[TB] FAIL frame_busy_req_ignored: got %0d bytes expected 7", tx_log.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL frame_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stall;
        logic [7:0] exp_b [7] = '{8'h55, 8'hab, 8'haa, 8'h20, 8'h01, 8'h13, 8'h57};
        logic [7:0] got;
        int hi_cnt;
        int v0;
        tx_log.delete();
        v0 = valid_cnt;
        hi_cnt = 0;
        pulse_send(8'h20, 16'h1357);
        wait_tx(2);
        tx_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (tx_start) hi_cnt++;
        end
        checks++; if (hi_cnt != 0) begin failures++; $display("[TB] FAIL stall_tx_start: got %0d high cycles expected 0", hi_cnt); end
        checks++; if (tx_log.size() != 2) begin failures++; $display("[TB] FAIL stall_bytes_held: got %0d expected 2", tx_log.size()); end
        tx_hold = 1'b0;
        wait_tx(7);
        for (int i = 0; i < 7; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin failures++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (start_viol != 0) begin failures++; $display("[TB] FAIL stall_start_not_ready: got %0d expected 0", start_viol); end
        repeat (3) @(negedge clk);
        send_rx(8'h66, 1'b0);
        send_rx(8'h77, 1'b0);
        wait_valid(v0);
        checks++; if (valid_data !== 16'h7766) begin failures++; $display("[TB] FAIL stall_resp_data: got %h expected 7766", valid_data); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_error;
        int v0;
        tx_log.delete();
        v0 = valid_cnt;
        pulse_send(8'h05, 16'hc3d4);
        wait_tx(7);
        repeat (3) @(negedge clk);
        send_rx(8'h10, 1'b1);
        send_rx(8'h20, 1'b0);
        wait_valid(v0);
        checks++; if (valid_err !== 1'b1) begin failures++; $display("[TB] FAIL error_flag: got %b expected 1", valid_err); end
        checks++; if (valid_data !== 16'h2010) begin failures++; $display("[TB] FAIL error_resp_data: got %h expected 2010", valid_data); end
        repeat (5) @(negedge clk);
        checks++; if (resp_err !== 1'b1) begin failures++; $display("[TB] FAIL error_sticky: got %b expected 1", resp_err); end
        tx_log.delete();
        v0 = valid_cnt;
        pulse_send(8'h06, 16'h0011);
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL error_cleared: got %b expected 0", resp_err); end
        wait_tx(7);
        repeat (3) @(negedge clk);
        send_rx(8'haa, 1'b0);
        send_rx(8'hbb, 1'b0);
        wait_valid(v0);
        checks++; if (valid_err !== 1'b0) begin failures++; $display("[TB] FAIL error_clean_flag: got %b expected 0", valid_err); end
        checks++; if (valid_data !== 16'hbbaa) begin failures++; $display("[TB] FAIL error_clean_data: got %h expected bbaa", valid_data); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] exp_b [7] = '{8'h55, 8'hab, 8'haa, 8'h0a, 8'h01, 8'hbe, 8'hef};
        logic [7:0] got;
        int v0;
        tx_log.delete();
        v0 = valid_cnt;
        pulse_send(8'h09, 16'h0102);
        wait_tx(4);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL abort_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL abort_tx_data: got %h expected 00", tx_data); end
        checks++; if (resp_data !== 16'h0000) begin failures++; $display("[TB] FAIL abort_resp_data: got %h expected 0000", resp_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++; if (valid_cnt != v0) begin failures++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", valid_cnt - v0); end
        checks++; if (tx_log.size() != 4) begin failures++; $display("[TB] FAIL abort_no_more_tx: got %0d bytes expected 4", tx_log.size()); end
        tx_log.delete();
        pulse_send(8'h0a, 16'hbeef);
        wait_tx(7);
        for (int i = 0; i < 7; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin failures++; $display("[TB] FAIL abort_restart_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        repeat (3) @(negedge clk);
        send_rx(8'h01, 1'b0);
        send_rx(8'h02, 1'b0);
        wait_valid(v0);
        checks++; if (valid_data !== 16'h0201) begin failures++; $display("[TB] FAIL abort_restart_resp: got %h expected 0201", valid_data); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout;
`ifdef RESP_TIMEOUT_EN
        int v0;
        int t0;
        int elapsed;
        tx_log.delete();
        v0 = valid_cnt;
        t0 = timeout_cnt;
        elapsed = 0;
        pulse_send(8'h0b, 16'h4455);
        wait_tx(7);
        for (int c = 0; c < 300 && timeout_cnt == t0; c++) begin
            @(negedge clk);
            elapsed++;
        end
        checks++; if (timeout_cnt - t0 != 1) begin failures++; $display("[TB] FAIL timeout_pulse: got %0d pulses expected 1", timeout_cnt - t0); end
        checks++; if (elapsed < 98 || elapsed > 105) begin failures++; $display("[TB] FAIL timeout_delay: got %0d cycles expected about 100", elapsed); end
        @(negedge clk);
        checks++; if (valid_cnt != v0) begin failures++; $display("[TB] FAIL timeout_no_valid: got %0d pulses expected 0", valid_cnt - v0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL timeout_one_cycle: got %b expected 0", timeout); end
`else
        checks++; if (timeout_cnt != 0) begin failures++; $display("[TB] FAIL timeout_tied_low: got %0d pulses expected 0", timeout_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_error();
        test_reset_abort();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
